alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture stage: MUL/DIV settle delay, then low/high word beats.
module alu_result_stage #(
  parameter int unsigned MULDIV_WAIT = 2,
  parameter logic [3:0]  CTRL_MUL    = 4'b1000,
  parameter logic [3:0]  CTRL_DIV    = 4'b1001
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [3:0]  iCtrl,
  input  logic [31:0] iC_hi,
  input  logic [31:0] iC_lo,
  input  logic        iZero,
  input  logic        iNeg,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oData,
  output logic        oSel_hi,
  output logic        oZero,
  output logic        oNeg,
  output logic        oBusy
);

  typedef enum logic [1:0] {IDLE, SETTLE, LO, HI} state_t;

  // The IDLE cycle counts as the first settle cycle, so SETTLE is loaded one short.
  localparam bit          NO_WAIT     = (MULDIV_WAIT == 0);
  localparam int unsigned SETTLE_INT  = (MULDIV_WAIT > 0) ? MULDIV_WAIT - 1 : 0;
  localparam logic [3:0]  SETTLE_LOAD = SETTLE_INT[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        wide_q, wide_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;
  logic        wide_op;
  logic        ready;

  assign wide_op = (iCtrl == CTRL_MUL) || (iCtrl == CTRL_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    wide_d  = wide_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (iValid) begin
          if (!wide_op || NO_WAIT) begin
            ready = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (!iValid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          ready = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LO: begin
        if (iReady) state_d = wide_q ? HI : IDLE;
      end
      HI: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (ready) begin
      lo_d    = iC_lo;
      hi_d    = iC_hi;
      wide_d  = wide_op;
      zero_d  = iZero;
      neg_d   = iNeg;
      state_d = LO;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      wide_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      wide_q  <= wide_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign oReady  = ready;
  assign oValid  = (state_q == LO) || (state_q == HI);
  assign oSel_hi = (state_q == HI);
  assign oData   = (state_q == HI) ? hi_q : ((state_q == LO) ? lo_q : 32'd0);
  assign oZero   = zero_q;
  assign oNeg    = neg_q;
  assign oBusy   = (state_q != IDLE);

endmodule
